// File: rtl/wb_sched_pkg.sv
// Shared types and constants for the integer register-file writeback path.
package wb_sched_pkg;

    localparam int WORD_SIZE = 32;
    localparam int REG_NUM   = 32;

    typedef logic [WORD_SIZE-1:0]       word_t;
    typedef logic [$clog2(REG_NUM)-1:0] reg_index_t;

    typedef enum logic {
        READ_REG_DATA  = 1'b0,
        WRITE_REG_DATA = 1'b1
    } reg_file_op_t;

    localparam int WB_ALU  = 0;
    localparam int WB_LOAD = 1;
    localparam int WB_CSR  = 2;

endpackage

// File: rtl/wb_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant and wraps.
module rr_arbiter #(
    parameter int N = 3,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         grant_any
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int cand;
            cand = (int'(last) + k) % N;
            if (!grant_any && req[cand]) begin
                grant_any       = 1'b1;
                grant[cand]     = 1'b1;
                grant_idx       = W'(cand);
            end
        end
    end

endmodule

// File: rtl/wb_sched.sv
// Writeback scheduler: arbitrates result sources onto the single register-file write
// port and tracks pending destinations for decode stalls.
module wb_sched
    import wb_sched_pkg::*;
#(
    parameter int N_REQ = 3,
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic       [N_REQ-1:0]        req_valid,
    input  reg_index_t [N_REQ-1:0]        req_rd,
    input  word_t      [N_REQ-1:0]        req_data,
    output logic       [N_REQ-1:0]        req_ready,
    output reg_file_op_t                  wb_op,
    output reg_index_t                    wb_rd,
    output word_t                         wb_data,
    input  logic                          issue_valid,
    input  reg_index_t                    issue_rd,
    output logic                          issue_ready,
    input  reg_index_t                    rs1_q,
    input  reg_index_t                    rs2_q,
    output logic                          rs1_busy,
    output logic                          rs2_busy,
    input  logic                          flush
);

    logic [PW-1:0]      rr_last;
    logic [PW-1:0]      grant_idx;
    logic               grant_any;
    logic [REG_NUM-1:0] pending;

    // Handshake: a requester transfers on the rising edge where req_valid[i] and
    // req_ready[i] are both high; until then it holds valid, rd and data stable.
    // The grant never depends on any downstream ready, so a grant is a transfer.
    rr_arbiter #(.N(N_REQ)) u_arb (
        .req       (req_valid),
        .last      (rr_last),
        .grant     (req_ready),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_op   <= READ_REG_DATA;
            wb_rd   <= '0;
            wb_data <= '0;
            rr_last <= PW'(N_REQ - 1);
        end else if (grant_any) begin
            rr_last <= grant_idx;
            wb_op   <= (req_rd[grant_idx] != '0) ? WRITE_REG_DATA : READ_REG_DATA;
            wb_rd   <= req_rd[grant_idx];
            wb_data <= req_data[grant_idx];
        end else begin
            wb_op   <= READ_REG_DATA;
        end
    end

    // A register already pending blocks a new issue even if its write commits this
    // same edge; that one-cycle stall keeps the ready path free of a bypass.
    assign issue_ready = !issue_valid || (issue_rd == '0) || !pending[issue_rd];

    assign rs1_busy = pending[rs1_q] && (rs1_q != '0);
    assign rs2_busy = pending[rs2_q] && (rs2_q != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else begin
            if (wb_op == WRITE_REG_DATA)
                pending[wb_rd] <= 1'b0;
            if (issue_valid && issue_ready && (issue_rd != '0))
                pending[issue_rd] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_sched.sv
// Directed bench for wb_sched: a queue of expected writeback commands checked by a monitor.
`timescale 1ns/1ps
module tb_wb_sched;
    import wb_sched_pkg::*;

    localparam int N_REQ = 3;
    localparam int EW    = 3 + 1 + 5 + 32;

    logic                   clock;
    logic                   reset;
    logic       [N_REQ-1:0] req_valid;
    reg_index_t [N_REQ-1:0] req_rd;
    word_t      [N_REQ-1:0] req_data;
    logic       [N_REQ-1:0] req_ready;
    reg_file_op_t           wb_op;
    reg_index_t             wb_rd;
    word_t                  wb_data;
    logic                   issue_valid;
    reg_index_t             issue_rd;
    logic                   issue_ready;
    reg_index_t             rs1_q;
    reg_index_t             rs2_q;
    logic                   rs1_busy;
    logic                   rs2_busy;
    logic                   flush;

    logic [EW-1:0] exp_q[$];
    int            n_cmp;
    int            n_err;
    logic          mon_en;

    wb_sched #(.N_REQ(N_REQ)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wb_op       (wb_op),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rs1_q       (rs1_q),
        .rs2_q       (rs2_q),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .flush       (flush)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // helpers and driver tasks
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] grant, input logic op, input logic [4:0] rd,
                            input logic [31:0] data);
        exp_q.push_back({grant, op, rd, data});
    endtask

    task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] data);
        req_valid[i] = 1'b1;
        req_rd[i]    = rd;
        req_data[i]  = data;
    endtask

    // monitor: grant checked on the handshake cycle, command one edge later
    initial begin
        logic [EW-1:0] prev;
        logic          have_prev;
        have_prev = 1'b0;
        prev      = '0;
        forever begin
            @(negedge clock);
            if (!mon_en) begin
                have_prev = 1'b0;
            end else begin
                if (have_prev) begin
                    check("wb_op",   64'(wb_op),   64'(prev[37]));
                    check("wb_rd",   64'(wb_rd),   64'(prev[36:32]));
                    check("wb_data", 64'(wb_data), 64'(prev[31:0]));
                end else begin
                    check("wb_op_idle", 64'(wb_op), 64'(READ_REG_DATA));
                end
                have_prev = 1'b0;
                if (|(req_valid & req_ready)) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_xfer", 64'(req_ready), 64'(0));
                    end else begin
                        prev = exp_q.pop_front();
                        check("req_ready", 64'(req_ready), 64'(prev[40:38]));
                        have_prev = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        mon_en      = 1'b0;
        reset       = 1'b1;
        req_valid   = '0;
        req_rd      = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        rs1_q       = '0;
        rs2_q       = '0;
        flush       = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_wb_op",   64'(wb_op),   64'(READ_REG_DATA));
        check("rst_wb_rd",   64'(wb_rd),   64'(0));
        check("rst_wb_data", 64'(wb_data), 64'(0));
        reset = 1'b0;
        rs1_q = 5'd5;
        rs2_q = 5'd31;
        #1;
        check("rst_req_ready",   64'(req_ready),   64'(0));
        check("rst_issue_ready", 64'(issue_ready), 64'(1));
        check("rst_rs1_busy",    64'(rs1_busy),    64'(0));
        check("rst_rs2_busy",    64'(rs2_busy),    64'(0));
        mon_en = 1'b1;

        // single load result
        set_req(WB_LOAD, 5'd5, 32'hDEADBEEF);
        push_exp(3'b010, WRITE_REG_DATA, 5'd5, 32'hDEADBEEF);
        step();
        req_valid = '0;
        repeat (2) step();

        // move pointer to CSR, then all three contend for six cycles
        set_req(WB_CSR, 5'd3, 32'h0000_0300);
        push_exp(3'b100, WRITE_REG_DATA, 5'd3, 32'h0000_0300);
        step();
        set_req(WB_ALU,  5'd1, 32'h0000_0101);
        set_req(WB_LOAD, 5'd2, 32'h0000_0202);
        for (int r = 0; r < 2; r++) begin
            push_exp(3'b001, WRITE_REG_DATA, 5'd1, 32'h0000_0101);
            push_exp(3'b010, WRITE_REG_DATA, 5'd2, 32'h0000_0202);
            push_exp(3'b100, WRITE_REG_DATA, 5'd3, 32'h0000_0300);
        end
        repeat (6) step();
        req_valid = '0;
        step();

        // scoreboard set, busy, blocked reissue, clear at commit
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        #1;
        check("issue7_ready", 64'(issue_ready), 64'(1));
        step();
        issue_valid = 1'b0;
        rs1_q       = 5'd7;
        #1;
        check("rs1_busy_7", 64'(rs1_busy), 64'(1));
        issue_valid = 1'b1;
        #1;
        check("reissue7_ready", 64'(issue_ready), 64'(0));
        issue_valid = 1'b0;
        set_req(WB_ALU, 5'd7, 32'h0000_0077);
        push_exp(3'b001, WRITE_REG_DATA, 5'd7, 32'h0000_0077);
        step();
        req_valid = '0;
        #1;
        check("rs1_busy_7_commit_cycle", 64'(rs1_busy), 64'(1));
        step();
        check("rs1_busy_7_cleared", 64'(rs1_busy), 64'(0));

        // writes and issues to x0
        set_req(WB_ALU, 5'd0, 32'h0000_1234);
        push_exp(3'b001, READ_REG_DATA, 5'd0, 32'h0000_1234);
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        rs1_q       = 5'd0;
        #1;
        check("issue0_ready", 64'(issue_ready), 64'(1));
        check("rs1_busy_0",   64'(rs1_busy),    64'(0));
        step();
        req_valid   = '0;
        issue_valid = 1'b0;
        #1;
        check("rs1_busy_0_after", 64'(rs1_busy), 64'(0));
        step();

        // flush wins over a same-edge set
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        step();
        issue_rd    = 5'd10;
        step();
        issue_valid = 1'b0;
        rs1_q       = 5'd9;
        rs2_q       = 5'd10;
        #1;
        check("rs1_busy_9",  64'(rs1_busy), 64'(1));
        check("rs2_busy_10", 64'(rs2_busy), 64'(1));
        issue_valid = 1'b1;
        issue_rd    = 5'd11;
        flush       = 1'b1;
        step();
        issue_valid = 1'b0;
        flush       = 1'b0;
        #1;
        check("flush_rs1_9",  64'(rs1_busy), 64'(0));
        check("flush_rs2_10", 64'(rs2_busy), 64'(0));
        rs1_q = 5'd11;
        #1;
        check("flush_rs1_11", 64'(rs1_busy), 64'(0));
        step();

        // async reset while a write command is presented
        mon_en = 1'b0;
        set_req(WB_LOAD, 5'd4, 32'h0000_0044);
        issue_valid = 1'b1;
        issue_rd    = 5'd12;
        step();
        req_valid   = '0;
        issue_valid = 1'b0;
        check("pre_reset_wb_op", 64'(wb_op), 64'(WRITE_REG_DATA));
        reset = 1'b1;
        #1;
        check("async_reset_wb_op", 64'(wb_op), 64'(READ_REG_DATA));
        check("async_reset_wb_rd", 64'(wb_rd), 64'(0));
        rs1_q = 5'd12;
        #1;
        check("async_reset_pending", 64'(rs1_busy), 64'(0));
        step();
        reset = 1'b0;
        set_req(WB_ALU,  5'd1, 32'h1);
        set_req(WB_LOAD, 5'd2, 32'h2);
        set_req(WB_CSR,  5'd3, 32'h3);
        #1;
        check("post_reset_grant", 64'(req_ready), 64'(3'b001));
        req_valid = '0;
        #1;
        mon_en = 1'b1;
        repeat (3) step();

        check("exp_q_drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
